arb_packet_framer: RTL

// Downstream stage of the round-robin FIFO arbiter. Captures the arbiter's
// 8-bit byte stream (dout/valid pair), buffers it in an internal FIFO, and emits

---
 rtl/arb_packet_framer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/arb_packet_framer.sv
// arb_packet_framer: buffers the arbiter byte stream in a small FIFO and emits
// framed packets (0xA5, length, payload, checksum) over a valid/ready interface.
// Optional feature macro: ARB_FRAMER_TIMEOUT_EN flushes short packets after an
// idle timeout; when undefined, bytes below PKT_LEN wait indefinitely.
module arb_packet_framer #(
  parameter int unsigned PKT_LEN    = 4,
  parameter int unsigned FIFO_DEPTH = 8
`ifdef ARB_FRAMER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 16
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  output logic [7:0]                    dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          sop,
  output logic                          eop,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] LEN  = 3'd2;
  localparam logic [2:0] PAY  = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    state;
  logic [LW-1:0] len;
  logic [LW-1:0] cnt;
  logic [7:0]    csum;
  logic [7:0]    head;
  logic [7:0]    len_byte;
  logic          full;
  logic          pop;
  logic          push;
  logic          start_full;
  logic          start_short;

  assign head     = mem[rd_ptr];
  assign len_byte = 8'(len);
  assign full     = (level == LW'(FIFO_DEPTH));
  assign pop      = (state == PAY) && dout_ready;
  // A pop at the same edge frees the slot, so a push on full is still accepted.
  assign push     = din_valid && (!full || pop);
  assign start_full = (state == IDLE) && (level >= LW'(PKT_LEN));

`ifdef ARB_FRAMER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          idle_cond;

  assign idle_cond   = (state == IDLE) && !din_valid && (level != '0) &&
                       (level < LW'(PKT_LEN));
  assign start_short = idle_cond && (idle_cnt == TW'(TIMEOUT));

  // Idle counter: runs only while a partial packet sits untouched in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (idle_cond && !start_short) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign start_short = 1'b0;
`endif

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
      if (din_valid && full && !pop) overflow <= 1'b1;
    end
  end

  // Frame sequencer; every state advances only on an accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
      csum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_full || start_short) begin
            state <= HDR;
            len   <= start_full ? LW'(PKT_LEN) : level;
            cnt   <= '0;
            csum  <= '0;
          end
        end
        HDR: if (dout_ready) state <= LEN;
        LEN: begin
          if (dout_ready) begin
            csum  <= csum + len_byte;
            state <= PAY;
          end
        end
        PAY: begin
          if (dout_ready) begin
            csum <= csum + head;
            cnt  <= cnt + 1'b1;
            if (cnt == len - 1'b1) state <= CSUM;
          end
        end
        CSUM: if (dout_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output byte and framing flags decoded from the current state.
  always_comb begin
    dout       = 8'h00;
    dout_valid = 1'b0;
    sop        = 1'b0;
    eop        = 1'b0;
    case (state)
      HDR: begin
        dout       = 8'hA5;
        dout_valid = 1'b1;
        sop        = 1'b1;
      end
      LEN: begin
        dout       = len_byte;
        dout_valid = 1'b1;
      end
      PAY: begin
        dout       = head;
        dout_valid = 1'b1;
      end
      CSUM: begin
        dout       = csum;
        dout_valid = 1'b1;
        eop        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
